// File: rtl/mem_pkg.sv
// Shared definitions for the scratch-memory family: controller states,
// byte-lane width and a constant-foldable ceil(log2) helper.
package mem_pkg;

   typedef enum logic [0:0] {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   localparam int LANE_W = 8;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_1rw_mask_array.sv
// Behavioural single-port storage with per-byte write enables and a registered
// read port. No reset on purpose so a hard macro can replace it one-for-one.
module mem_1rw_mask_array
   import mem_pkg::*;
#(
   parameter  int WIDTH_P = 32,
   parameter  int ELS_P   = 64,
   localparam int ADDR_W  = clog2(ELS_P),
   localparam int LANES   = WIDTH_P / LANE_W
) (
   input  logic               clk_i,
   input  logic               v_i,
   input  logic               w_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [WIDTH_P-1:0] data_i,
   input  logic [LANES-1:0]   w_mask_i,
   output logic [WIDTH_P-1:0] data_o
);

   logic [WIDTH_P-1:0] mem_r [ELS_P];
   logic [WIDTH_P-1:0] rd_data_r;

   // One access per edge: masked lane write, or read into the output register.
   always_ff @(posedge clk_i) begin
      if (v_i && w_i) begin
         for (int k = 0; k < LANES; k++) begin
            if (w_mask_i[k]) begin
               mem_r[addr_i][k*LANE_W +: LANE_W] <= data_i[k*LANE_W +: LANE_W];
            end
         end
      end else if (v_i) begin
         rd_data_r <= mem_r[addr_i];
      end
   end

   assign data_o = rd_data_r;

endmodule

// File: rtl/mem_1rw_mask.sv
// Single-port masked memory with valid/ready request port and a built-in
// zero-fill sequencer that runs after reset and on clear_i.
module mem_1rw_mask
   import mem_pkg::*;
#(
   parameter  int WIDTH_P = 32,
   parameter  int ELS_P   = 64,
   localparam int ADDR_W  = clog2(ELS_P),
   localparam int LANES   = WIDTH_P / LANE_W
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               clear_i,
   input  logic               v_i,
   input  logic               w_i,
   input  logic [ADDR_W-1:0]  addr_i,
   input  logic [WIDTH_P-1:0] data_i,
   input  logic [LANES-1:0]   w_mask_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [WIDTH_P-1:0] data_o
);

   state_e              state_r;
   state_e              state_nxt_s;
   logic [ADDR_W-1:0]   cnt_r;
   logic                init_last_s;
   logic                init_s;
   logic                ready_s;
   logic                accept_s;
   logic                in_range_s;
   logic                rd_accept_s;
   logic                v_r;
   logic                sel_r;

   logic                arr_v_s;
   logic                arr_w_s;
   logic [ADDR_W-1:0]   arr_addr_s;
   logic [WIDTH_P-1:0]  arr_wdata_s;
   logic [LANES-1:0]    arr_mask_s;
   logic [WIDTH_P-1:0]  arr_rdata_s;

   // Terminal compare against the real depth so odd sizes never wrap early.
   assign init_last_s = (cnt_r == ADDR_W'(ELS_P - 1));
   assign in_range_s  = ($unsigned(32'(addr_i)) < $unsigned(32'(ELS_P)));
   assign accept_s    = v_i & ready_s;
   assign rd_accept_s = accept_s & ~w_i;

   // FSM state register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= INIT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; clear_i wins over any concurrent request.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         INIT: begin
            if (init_last_s) begin
               state_nxt_s = READY;
            end else begin
               state_nxt_s = INIT;
            end
         end
         READY: begin
            if (clear_i) begin
               state_nxt_s = INIT;
            end else begin
               state_nxt_s = READY;
            end
         end
         default: state_nxt_s = INIT;
      endcase
   end

   // FSM outputs.
   always_comb begin
      init_s  = 1'b0;
      ready_s = 1'b0;
      case (state_r)
         INIT:    init_s  = 1'b1;
         READY:   ready_s = ~clear_i;
         default: begin
            init_s  = 1'b0;
            ready_s = 1'b0;
         end
      endcase
   end

   // Zero-fill address counter; parked at zero outside INIT.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_r <= {ADDR_W{1'b0}};
      end else if (init_s && !init_last_s) begin
         cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= {ADDR_W{1'b0}};
      end
   end

   // Array port mux: init owns the port in INIT, out-of-range requests never reach it.
   always_comb begin
      arr_v_s     = 1'b0;
      arr_w_s     = 1'b0;
      arr_addr_s  = addr_i;
      arr_wdata_s = data_i;
      arr_mask_s  = w_mask_i;
      if (init_s) begin
         arr_v_s     = 1'b1;
         arr_w_s     = 1'b1;
         arr_addr_s  = cnt_r;
         arr_wdata_s = {WIDTH_P{1'b0}};
         arr_mask_s  = {LANES{1'b1}};
      end else begin
         arr_v_s     = accept_s & in_range_s;
         arr_w_s     = w_i;
      end
   end

   // Read strobe and output select. sel_r gates the unreset array register so
   // data_o is zero after reset and for out-of-range reads, and holds otherwise.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_r   <= 1'b0;
         sel_r <= 1'b0;
      end else begin
         v_r <= rd_accept_s;
         if (rd_accept_s) begin
            sel_r <= in_range_s;
         end
      end
   end

   mem_1rw_mask_array #(
      .WIDTH_P (WIDTH_P),
      .ELS_P   (ELS_P)
   ) u_array (
      .clk_i    (clk_i),
      .v_i      (arr_v_s),
      .w_i      (arr_w_s),
      .addr_i   (arr_addr_s),
      .data_i   (arr_wdata_s),
      .w_mask_i (arr_mask_s),
      .data_o   (arr_rdata_s)
   );

   assign ready_o = ready_s;
   assign v_o     = v_r;
   assign data_o  = sel_r ? arr_rdata_s : {WIDTH_P{1'b0}};

endmodule

// File: tb/tb_mem_1rw_mask.sv
// Directed bench for mem_1rw_mask: a 64-deep instance (a) and a 20-deep
// instance (b) exercised in turn, with hand-computed expected values.
module tb_mem_1rw_mask;

   logic        clk;
   int          errors;
   int          checks;

   logic        rst_a, clr_a, v_a, w_a, rdy_a, vo_a;
   logic [5:0]  addr_a;
   logic [31:0] din_a, dout_a;
   logic [3:0]  mask_a;

   logic        rst_b, clr_b, v_b, w_b, rdy_b, vo_b;
   logic [4:0]  addr_b;
   logic [31:0] din_b, dout_b;
   logic [3:0]  mask_b;

   mem_1rw_mask #(.WIDTH_P(32), .ELS_P(64)) dut_a (
      .clk_i(clk), .reset_n_i(rst_a), .clear_i(clr_a), .v_i(v_a), .w_i(w_a),
      .addr_i(addr_a), .data_i(din_a), .w_mask_i(mask_a),
      .ready_o(rdy_a), .v_o(vo_a), .data_o(dout_a)
   );

   mem_1rw_mask #(.WIDTH_P(32), .ELS_P(20)) dut_b (
      .clk_i(clk), .reset_n_i(rst_b), .clear_i(clr_b), .v_i(v_b), .w_i(w_b),
      .addr_i(addr_b), .data_i(din_b), .w_mask_i(mask_b),
      .ready_o(rdy_b), .v_o(vo_b), .data_o(dout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive(input bit b, input logic v, input logic w, input int addr,
                        input logic [31:0] d, input logic [3:0] m);
      if (b) begin
         v_b = v; w_b = w; addr_b = 5'(addr); din_b = d; mask_b = m;
      end else begin
         v_a = v; w_a = w; addr_a = 6'(addr); din_a = d; mask_a = m;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input bit b, input int addr, input logic [31:0] d, input logic [3:0] m);
      drive(b, 1'b1, 1'b1, addr, d, m);
      step();
      drive(b, 1'b0, 1'b0, 0, 32'h0, 4'h0);
   endtask

   task automatic rd(input bit b, input int addr, input logic [31:0] exp);
      drive(b, 1'b1, 1'b0, addr, 32'h0, 4'h0);
      step();
      drive(b, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      chk($sformatf("%s_rd%0d_v", b ? "b" : "a", addr), {31'd0, b ? vo_b : vo_a}, 32'd1);
      chk($sformatf("%s_rd%0d_data", b ? "b" : "a", addr), b ? dout_b : dout_a, exp);
   endtask

   // Counts edges until ready_o rises, bounded so a stuck INIT still reports.
   task automatic wait_ready(input bit b, input string tag, input int exp);
      int n;
      n = 0;
      while (!(b ? rdy_b : rdy_a) && n < 300) begin
         step();
         n++;
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      errors = 0;
      checks = 0;
      rst_a = 1'b0; clr_a = 1'b0;
      rst_b = 1'b0; clr_b = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      repeat (2) step();

      chk("reset_ready", {31'd0, rdy_a}, 32'd0);
      chk("reset_v", {31'd0, vo_a}, 32'd0);
      chk("reset_data", dout_a, 32'h0);

      rst_a = 1'b1;
      wait_ready(1'b0, "init_len_64", 64);
      rd(1'b0, 0, 32'h0);
      rd(1'b0, 31, 32'h0);
      rd(1'b0, 63, 32'h0);

      wr(1'b0, 5, 32'hAABBCCDD, 4'b1111);
      wr(1'b0, 5, 32'h11223344, 4'b0101);
      rd(1'b0, 5, 32'hAA22CC44);

      wr(1'b0, 7, 32'h12345678, 4'b1111);
      rd(1'b0, 7, 32'h12345678);
      wr(1'b0, 7, 32'hFFFFFFFF, 4'b0000);
      rd(1'b0, 7, 32'h12345678);

      // Three back-to-back reads, then the strobe drops and data holds.
      drive(1'b0, 1'b1, 1'b0, 5, 32'h0, 4'h0);
      step();
      chk("b2b_v1", {31'd0, vo_a}, 32'd1);
      chk("b2b_d1", dout_a, 32'hAA22CC44);
      drive(1'b0, 1'b1, 1'b0, 7, 32'h0, 4'h0);
      step();
      chk("b2b_v2", {31'd0, vo_a}, 32'd1);
      chk("b2b_d2", dout_a, 32'h12345678);
      drive(1'b0, 1'b1, 1'b0, 5, 32'h0, 4'h0);
      step();
      chk("b2b_v3", {31'd0, vo_a}, 32'd1);
      chk("b2b_d3", dout_a, 32'hAA22CC44);
      drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      step();
      chk("hold_v", {31'd0, vo_a}, 32'd0);
      chk("hold_data", dout_a, 32'hAA22CC44);

      // clear_i with a concurrent read: request refused, memory re-zeroed.
      clr_a = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 7, 32'h0, 4'h0);
      #1;
      chk("clear_ready_low", {31'd0, rdy_a}, 32'd0);
      step();
      clr_a = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      chk("clear_no_v", {31'd0, vo_a}, 32'd0);
      chk("clear_data_held", dout_a, 32'hAA22CC44);
      wait_ready(1'b0, "clear_len_64", 64);
      rd(1'b0, 5, 32'h0);

      // Asynchronous reset right after a read is accepted.
      wr(1'b0, 5, 32'h5A5A5A5A, 4'b1111);
      drive(1'b0, 1'b1, 1'b0, 5, 32'h0, 4'h0);
      step();
      chk("midrst_pre_v", {31'd0, vo_a}, 32'd1);
      chk("midrst_pre_data", dout_a, 32'h5A5A5A5A);
      #2;
      rst_a = 1'b0;
      #1;
      chk("midrst_v", {31'd0, vo_a}, 32'd0);
      chk("midrst_data", dout_a, 32'h0);
      chk("midrst_ready", {31'd0, rdy_a}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      step();
      rst_a = 1'b1;
      wait_ready(1'b0, "reinit_len_64", 64);
      rd(1'b0, 5, 32'h0);

      // Non-power-of-two depth.
      rst_b = 1'b1;
      wait_ready(1'b1, "init_len_20", 20);
      wr(1'b1, 25, 32'hFFFFFFFF, 4'b1111);
      rd(1'b1, 25, 32'h0);
      rd(1'b1, 9, 32'h0);
      wr(1'b1, 19, 32'hDEADBEEF, 4'b1111);
      rd(1'b1, 19, 32'hDEADBEEF);
      rd(1'b1, 25, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
